// File: rtl/id_ctl_gen.sv
// Decode-side execute control bundle generator: registered decode with stall/flush and a RUN/HALTED FSM.
// Optional macro ID_CTL_IO_EN enables decoding of IN/OUT; otherwise they are flagged illegal.
module id_ctl_gen #(
    parameter logic [3:0] NOP_OPCODE = 4'b0000,
    parameter logic [3:0] LI_OPCODE  = 4'b0110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] inst_in,
    input  logic        inst_valid_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        resume,
    output logic        alu_src1,
    output logic        alu_src2,
    output logic        alu_or_shifter,
    output logic        as_bc,
    output logic [3:0]  opcode,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        ctl_valid,
    output logic        illegal,
    output logic        halted
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_MOV = 4'b0110;

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic       alu_src1;
        logic       alu_src2;
        logic       alu_or_shifter;
        logic       as_bc;
        logic [3:0] opcode;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       ctl_valid;
        logic       illegal;
    } ctl_t;

    state_t state_reg, state_next;
    ctl_t   ctl_reg, ctl_next;
    ctl_t   dec;
    ctl_t   bubble;
    logic   dec_hlt;

    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] op3;

    assign op1 = inst_in[15:14];
    assign op2 = inst_in[13:11];
    assign op3 = inst_in[7:4];

    // Register fields and immediates are consumed elsewhere in the pipeline.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_in[10:8], inst_in[3:0]};

    always_comb begin
        bubble        = '0;
        bubble.opcode = NOP_OPCODE;
    end

    // Pure decode of the instruction word; every decoded word is valid, even illegal ones.
    always_comb begin
        dec           = '0;
        dec.opcode    = NOP_OPCODE;
        dec.ctl_valid = 1'b1;
        dec_hlt       = 1'b0;
        case (op1)
            2'b11: begin
                case (op3)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011,
                    4'b0100, 4'b0101, 4'b0110: begin
                        dec.opcode    = op3;
                        dec.reg_write = (op3 != 4'b0101);
                    end
                    4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                        dec.alu_or_shifter = 1'b1;
                        dec.alu_src2       = 1'b1;
                        dec.opcode         = op3;
                        dec.reg_write      = 1'b1;
                    end
`ifdef ID_CTL_IO_EN
                    4'b1100: begin
                        dec.opcode    = OP_MOV;
                        dec.reg_write = 1'b1;
                    end
                    4'b1101: begin
                        dec.opcode = OP_MOV;
                    end
`else
                    4'b1100, 4'b1101: begin
                        dec.illegal = 1'b1;
                    end
`endif
                    4'b1111: begin
                        dec_hlt = 1'b1;
                    end
                    default: begin
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            2'b00: begin
                dec.alu_src2  = 1'b1;
                dec.opcode    = OP_ADD;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            2'b01: begin
                dec.alu_src2  = 1'b1;
                dec.opcode    = OP_ADD;
                dec.mem_write = 1'b1;
            end
            default: begin
                case (op2)
                    3'b000: begin
                        dec.alu_src2  = 1'b1;
                        dec.opcode    = LI_OPCODE;
                        dec.reg_write = 1'b1;
                    end
                    3'b100: begin
                        dec.alu_src1 = 1'b1;
                        dec.alu_src2 = 1'b1;
                        dec.opcode   = OP_ADD;
                    end
                    3'b111: begin
                        dec.alu_src1 = 1'b1;
                        dec.alu_src2 = 1'b1;
                        dec.as_bc    = 1'b1;
                        dec.opcode   = OP_ADD;
                    end
                    default: begin
                        dec.illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Edge priority: stall holds everything, flush forces a bubble and RUN, then capture.
    always_comb begin
        state_next = state_reg;
        ctl_next   = ctl_reg;
        if (!stall) begin
            if (flush) begin
                ctl_next   = bubble;
                state_next = RUN;
            end else if (state_reg == RUN && inst_valid_in) begin
                ctl_next   = dec;
                state_next = dec_hlt ? HALTED : RUN;
            end else begin
                ctl_next = bubble;
                if (state_reg == HALTED && resume) begin
                    state_next = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            ctl_reg   <= bubble;
        end else begin
            state_reg <= state_next;
            ctl_reg   <= ctl_next;
        end
    end

    assign alu_src1       = ctl_reg.alu_src1;
    assign alu_src2       = ctl_reg.alu_src2;
    assign alu_or_shifter = ctl_reg.alu_or_shifter;
    assign as_bc          = ctl_reg.as_bc;
    assign opcode         = ctl_reg.opcode;
    assign mem_read       = ctl_reg.mem_read;
    assign mem_write      = ctl_reg.mem_write;
    assign reg_write      = ctl_reg.reg_write;
    assign ctl_valid      = ctl_reg.ctl_valid;
    assign illegal        = ctl_reg.illegal;
    assign halted         = (state_reg == HALTED);

endmodule

// File: tb/tb_id_ctl_gen.sv
// Directed bench for id_ctl_gen: a decode vector table plus stall, halt/resume, flush and async-reset sequences.
// Expected word layout: {halted, src1, src2, alu_or_shifter, as_bc, opcode[3:0], mem_read, mem_write, reg_write, ctl_valid, illegal}.
module tb_id_ctl_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] inst_in;
    logic        inst_valid_in;
    logic        stall;
    logic        flush;
    logic        resume;
    logic        alu_src1, alu_src2, alu_or_shifter, as_bc;
    logic [3:0]  opcode;
    logic        mem_read, mem_write, reg_write, ctl_valid, illegal, halted;

    int checks   = 0;
    int failures = 0;

    id_ctl_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_in        (inst_in),
        .inst_valid_in  (inst_valid_in),
        .stall          (stall),
        .flush          (flush),
        .resume         (resume),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .alu_or_shifter (alu_or_shifter),
        .as_bc          (as_bc),
        .opcode         (opcode),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .reg_write      (reg_write),
        .ctl_valid      (ctl_valid),
        .illegal        (illegal),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    localparam logic [13:0] E_ZERO = 14'b0_0000_0000_00000;
    localparam logic [13:0] E_ADD  = 14'b0_0000_0000_00110;
    localparam logic [13:0] E_LD   = 14'b0_0100_0000_10110;
    localparam logic [13:0] E_ILL  = 14'b0_0000_0000_00011;
    localparam logic [13:0] E_HLT  = 14'b1_0000_0000_00010;
    localparam logic [13:0] E_HALT_BUB = 14'b1_0000_0000_00000;

    typedef struct {
        string       name;
        logic [15:0] inst;
        logic        valid;
        logic        fl;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] got;
        got = {halted, alu_src1, alu_src2, alu_or_shifter, as_bc, opcode,
               mem_read, mem_write, reg_write, ctl_valid, illegal};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end else begin
            $display("ok   %s got=%b", name, got);
        end
    endtask

    task automatic drive(input logic [15:0] i, input logic v, input logic s,
                         input logic f, input logic r);
        inst_in = i; inst_valid_in = v; stall = s; flush = f; resume = r;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"add",      16'hD100, 1'b1, 1'b0, E_ADD};
        vecs[1]  = '{"sll",      16'hC183, 1'b1, 1'b0, 14'b0_0110_1000_00110};
        vecs[2]  = '{"li",       16'h8305, 1'b1, 1'b0, 14'b0_0100_0110_00110};
        vecs[3]  = '{"bcond",    16'hB805, 1'b1, 1'b0, 14'b0_1101_0000_00010};
        vecs[4]  = '{"bcond_fl", 16'hB805, 1'b1, 1'b1, E_ZERO};
        vecs[5]  = '{"cmp",      16'hD150, 1'b1, 1'b0, 14'b0_0000_0101_00010};
        vecs[6]  = '{"mov",      16'hC060, 1'b1, 1'b0, 14'b0_0000_0110_00110};
        vecs[7]  = '{"sra",      16'hC1B0, 1'b1, 1'b0, 14'b0_0110_1011_00110};
        vecs[8]  = '{"ld",       16'h0000, 1'b1, 1'b0, E_LD};
        vecs[9]  = '{"st",       16'h4000, 1'b1, 1'b0, 14'b0_0100_0000_01010};
        vecs[10] = '{"b",        16'hA000, 1'b1, 1'b0, 14'b0_1100_0000_00010};
        vecs[11] = '{"ill_op2",  16'h8800, 1'b1, 1'b0, E_ILL};
        vecs[12] = '{"ill_0111", 16'hC070, 1'b1, 1'b0, E_ILL};
        vecs[13] = '{"ill_1110", 16'hC0E0, 1'b1, 1'b0, E_ILL};
        vecs[14] = '{"novalid",  16'hD100, 1'b0, 1'b0, E_ZERO};
        vecs[15] = '{"ld_fl",    16'h0000, 1'b1, 1'b1, E_ZERO};
`ifdef ID_CTL_IO_EN
        vecs[16] = '{"in",       16'hC0C0, 1'b1, 1'b0, 14'b0_0000_0110_00110};
        vecs[17] = '{"out",      16'hC0D0, 1'b1, 1'b0, 14'b0_0000_0110_00010};
`else
        vecs[16] = '{"in",       16'hC0C0, 1'b1, 1'b0, E_ILL};
        vecs[17] = '{"out",      16'hC0D0, 1'b1, 1'b0, E_ILL};
`endif
        vecs[18] = '{"add2",     16'hD100, 1'b1, 1'b0, E_ADD};

        rst_n = 1'b0;
        drive(16'hD100, 1'b1, 1'b0, 1'b0, 1'b0);
        #12;
        check("reset", E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].inst, vecs[k].valid, 1'b0, vecs[k].fl, 1'b0);
            tick();
            check(vecs[k].name, vecs[k].exp);
        end

        // Stall freezes the ADD bundle while the fetched word changes to LD.
        drive(16'hD100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("stall_pre", E_ADD);
        drive(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall_hold%0d", c), E_ADD);
        end
        drive(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("stall_release", E_LD);

        // Halt, ignore valid words, resume, then capture again.
        drive(16'hC0F0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("hlt", E_HLT);
        drive(16'hD100, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("halted_ign%0d", c), E_HALT_BUB);
        end
        drive(16'hD100, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("resume", E_ZERO);
        drive(16'hD100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("after_resume", E_ADD);

        // Stall beats resume in HALTED; flush then leaves HALTED.
        drive(16'hC0F0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("hlt2", E_HLT);
        drive(16'hD100, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("halted_stall", E_HLT);
        drive(16'hD100, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("halted_flush", E_ZERO);
        drive(16'hD100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("after_flush_run", E_ADD);

        // Flush on the HLT edge discards it.
        drive(16'hC0F0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("hlt_flushed", E_ZERO);
        drive(16'hD100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("hlt_flushed_next", E_ADD);

        // Async reset while halted clears outputs before any clock edge.
        drive(16'hC0F0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("hlt3", E_HLT);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'hD100, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("post_reset_add", E_ADD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ctl_gen.md
Name: id_ctl_gen

Overview:
- Decode-side producer of the per-instruction execute control bundle for the SIMPLE 5-phase pipeline.
- Takes the fetched 16-bit instruction from phase 2 and decodes operand-select, ALU/shifter, branch-compare and opcode controls, plus memory and writeback enables.
- Registers the result once, with stall/flush handling and a halt state machine, so the downstream phase-3 control register sees a clean, valid-qualified bundle.

Parameters:
- NOP_OPCODE, 4'b0000, ALU opcode driven on bubbles.
- LI_OPCODE, 4'b0110, ALU opcode for LI (MOV: pass operand B).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inst_in  in  16  instruction word from fetch.
- inst_valid_in  in  1  inst_in is valid this cycle.
- stall  in  1  hold all outputs and state.
- flush  in  1  kill the bundle being captured; insert a bubble.
- resume  in  1  one-cycle pulse: leave HALTED.
- alu_src1  out  1  0 = register Rd data, 1 = PC.
- alu_src2  out  1  0 = register Rs data, 1 = sign-extended immediate.
- alu_or_shifter  out  1  0 = ALU result, 1 = shifter result.
- as_bc  out  1  0 = arithmetic/shift result, 1 = branch-compare path.
- opcode  out  4  ALU/shifter function.
- mem_read, mem_write, reg_write  out  1 each  stage enables.
- ctl_valid  out  1  bundle is a real instruction.
- illegal  out  1  captured word is an undefined encoding.
- halted  out  1  FSM is in HALTED.

Behaviour:
- Reset: async on rst_n low. All outputs 0, opcode = NOP_OPCODE, FSM = RUN.
- Latency: 1 cycle from capture edge to outputs.
- Per-edge priority: reset > stall > flush > capture.
- stall=1: all outputs and FSM state hold, including HALTED.
- flush=1 (no stall): load bubble (all enables 0, ctl_valid 0, opcode NOP_OPCODE, illegal 0). Flush in HALTED returns FSM to RUN. Flush on the same edge as an HLT capture discards the HLT; FSM stays RUN.
- Capture: RUN, inst_valid_in=1, no stall/flush. Otherwise a bubble is loaded.
- Decode of op1 = inst[15:14]:
  - 11: op3 = inst[7:4].
    - ADD..MOV (0000-0110): opcode = op3, alu_src2 = 0, reg_write = 1 except CMP (0101).
    - SLL/SLR/SRL/SRA (1000-1011): alu_or_shifter = 1, alu_src2 = 1, opcode = op3, reg_write = 1.
    - IN/OUT (1100/1101): see optional feature.
    - HLT (1111): ctl_valid = 1, no enables; FSM RUN -> HALTED.
    - 0111, 1110: illegal = 1, ctl_valid = 1, no enables.
  - 00 LD: alu_src2 = 1, opcode = ADD, mem_read = 1, reg_write = 1.
  - 01 ST: alu_src2 = 1, opcode = ADD, mem_write = 1.
  - 10: op2 = inst[13:11].
    - 000 LI: alu_src2 = 1, opcode = LI_OPCODE, reg_write = 1.
    - 100 B: alu_src1 = 1, alu_src2 = 1, opcode = ADD.
    - 111 Bcond: alu_src1 = 1, alu_src2 = 1, as_bc = 1, opcode = ADD.
    - other op2: illegal = 1.
- ctl_valid = 1 on every captured word, including illegal ones.
- HALTED: inst_valid_in ignored, bubbles issued, halted = 1. resume (no stall) -> RUN on next edge; halted drops with it. resume in RUN is ignored.
- Reset mid-operation: immediate return to reset values; the pending bundle is lost.

Optional Feature:
- Macro: ID_CTL_IO_EN.
- Defined: IN decodes to reg_write = 1, opcode = MOV, alu_src2 = 0. OUT decodes to opcode = MOV with no enables. Both set ctl_valid = 1, illegal = 0.
- Undefined: IN/OUT flag illegal = 1, ctl_valid = 1, no enables.

Test Plan:
- Reset, then inst_in = 0xD100 (ADD R1,R2) valid -> next edge: ctl_valid 1, opcode 0000, reg_write 1, alu_src1/alu_src2/alu_or_shifter/as_bc 0.
- 0xC183 (SLL R1,3) -> alu_or_shifter 1, alu_src2 1, opcode 1000, reg_write 1. Then 0x8305 (LI R3,5) -> opcode 0110, alu_src2 1, reg_write 1.
- 0xB805 (BE +5) -> alu_src1 1, alu_src2 1, as_bc 1, opcode 0000, reg_write 0. Same word with flush=1 -> ctl_valid 0, all enables 0.
- Capture 0xD100 with stall held 3 cycles while inst_in changes to 0x0000 -> outputs frozen as ADD for all 3 cycles. Release stall -> LD bundle (mem_read 1, reg_write 1) one edge later.
- 0xC0F0 (HLT) -> halted 1 next edge; 4 valid instructions ignored (ctl_valid 0). resume pulse -> halted 0 and next valid 0xD100 captured. Repeat with flush on the HLT edge -> halted stays 0.
- 0xC0C0 (IN) -> with ID_CTL_IO_EN: reg_write 1, illegal 0. Without: illegal 1, reg_write 0. Assert rst_n low mid-stream -> all outputs 0 asynchronously, before the next clock edge.
